// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 8 lines x 16 bytes, single-block refill
// from instruction memory over a read/busywait handshake.
module instruction_cache (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [9:0]   address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readinst,
    input  logic         mem_busywait
);

    localparam int unsigned LINES   = 8;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_e;

    state_e                   state_q, state_d;
    logic [TAG_W+IDX_W-1:0]   miss_q, miss_d;
    logic [LINES-1:0]         valid_q, valid_d;
    logic [TAG_W-1:0]         tag_q  [LINES];
    logic [BLOCK_W-1:0]       data_q [LINES];
    logic                     fill_c;

    logic [TAG_W-1:0]         addr_tag_c;
    logic [IDX_W-1:0]         addr_idx_c;
    logic [1:0]               addr_off_c;
    logic                     hit_c;
    logic [BLOCK_W-1:0]       line_c;

    assign addr_tag_c = address[9:7];
    assign addr_idx_c = address[6:4];
    assign addr_off_c = address[3:2];

    // Lookup and word select against the current fetch address
    assign hit_c       = valid_q[addr_idx_c] && (tag_q[addr_idx_c] == addr_tag_c);
    assign line_c      = data_q[addr_idx_c];
    assign instruction = hit_c ? line_c[{addr_off_c, 5'b0} +: WORD_W] : '0;

    // Stall is forced low while reset is held so the CPU sees a quiet cache
    assign busywait    = reset_n && ((state_q != IDLE) || !hit_c);
    assign mem_read    = (state_q == MEM_READ);
    assign mem_address = miss_q;

    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        valid_d = valid_q;
        fill_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hit_c && !mem_busywait) begin
                    miss_d  = address[9:4];
                    state_d = MEM_READ;
                end
            end
            MEM_READ: begin
                if (!mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                fill_c                   = 1'b1;
                valid_d[miss_q[IDX_W-1:0]] = 1'b1;
                state_d                  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            miss_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            valid_q <= valid_d;
        end
    end

    // Tag/data arrays carry no reset; the valid bits qualify them
    always_ff @(posedge clock) begin
        if (fill_c) begin
            tag_q[miss_q[IDX_W-1:0]]  <= miss_q[TAG_W+IDX_W-1:IDX_W];
            data_q[miss_q[IDX_W-1:0]] <= mem_readinst;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a fixed-latency block memory model.
module tb_instruction_cache;

    logic         clock;
    logic         reset_n;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst = '0;
    logic         mem_busywait = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic       mem_hold   = 1'b0;
    logic       mem_active = 1'b0;
    int         mem_cnt    = 0;
    logic [5:0] mem_blk    = '0;
    logic [5:0] last_blk   = '0;
    int         reads      = 0;

    localparam int LAT = 2;

    instruction_cache dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readinst (mem_readinst),
        .mem_busywait (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Distinct word per (block, offset) so wrong block or wrong word shows up
    function automatic logic [31:0] exp_word(input logic [9:0] a);
        logic [5:0] b;
        logic [1:0] w;
        b = a[9:4];
        w = a[3:2];
        return {{2'b00, b}, {6'b0, w}, ~{2'b00, b}, 8'h5A ^ {6'b0, w}};
    endfunction

    function automatic logic [127:0] exp_block(input logic [5:0] b);
        logic [127:0] r;
        r = '0;
        for (int w = 0; w < 4; w++) begin
            r[32*w +: 32] = exp_word({b, 2'(w), 2'b00});
        end
        return r;
    endfunction

    // Memory: raises busywait after seeing mem_read, returns block LAT+1 cycles later
    always @(posedge clock) begin
        #1;
        if (mem_active) begin
            if (mem_cnt == 0) begin
                mem_readinst = exp_block(mem_blk);
                mem_active   = 1'b0;
            end else begin
                mem_cnt = mem_cnt - 1;
            end
        end else if (mem_read) begin
            mem_active = 1'b1;
            mem_cnt    = LAT;
            mem_blk    = mem_address;
            last_blk   = mem_address;
            reads      = reads + 1;
        end
        mem_busywait = mem_hold || mem_active;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (busywait && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(busywait), 32'd0);
    endtask

    task automatic wait_mem_read(input logic [5:0] blk);
        int n;
        n = 0;
        while (!(mem_read && mem_address == blk) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("mem_read_seen", {26'b0, mem_address}, {26'b0, blk});
    endtask

    task automatic fetch(input logic [9:0] a, output int stalls);
        @(negedge clock);
        address = a;
        #1;
        wait_ready(stalls);
    endtask

    int  st;
    int  r0;
    logic bad;

    initial begin
        reset_n = 1'b0;
        address = 10'h000;

        #12;
        check("rst_busywait", 32'(busywait), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_addr", 32'(mem_address), 32'd0);
        check("rst_instr", instruction, 32'd0);

        // Cold miss
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("cold_busy", 32'(busywait), 32'd1);
        @(negedge clock);
        check("cold_mem_read", 32'(mem_read), 32'd1);
        check("cold_mem_addr", 32'(mem_address), 32'h00);
        wait_ready(st);
        check("cold_stall", 32'(st + 1), 32'd6);
        check("cold_instr", instruction, exp_word(10'h000));
        check("cold_reads", 32'(reads), 32'd1);

        // Spatial hits in block 0
        for (int i = 1; i < 4; i++) begin
            fetch(10'(4 * i), st);
            check("spatial_stall", 32'(st), 32'd0);
            check("spatial_instr", instruction, exp_word(10'(4 * i)));
        end
        check("spatial_reads", 32'(reads), 32'd1);

        // Conflict eviction on index 0
        fetch(10'h080, st);
        check("conf1_stall", 32'(st), 32'd6);
        check("conf1_blk", 32'(last_blk), 32'h08);
        check("conf1_instr", instruction, exp_word(10'h080));
        fetch(10'h000, st);
        check("conf2_stall", 32'(st), 32'd6);
        check("conf2_blk", 32'(last_blk), 32'h00);
        check("conf2_instr", instruction, exp_word(10'h000));
        check("conf_reads", 32'(reads), 32'd3);

        // Independent lines 1 and 7
        fetch(10'h010, st);
        check("ind_fill1", instruction, exp_word(10'h010));
        fetch(10'h070, st);
        check("ind_fill7", instruction, exp_word(10'h070));
        r0 = reads;
        for (int i = 0; i < 2; i++) begin
            fetch(10'h014, st);
            check("ind_stall_a", 32'(st), 32'd0);
            check("ind_instr_a", instruction, exp_word(10'h014));
            fetch(10'h07C, st);
            check("ind_stall_b", 32'(st), 32'd0);
            check("ind_instr_b", instruction, exp_word(10'h07C));
        end
        check("ind_reads", 32'(reads), 32'(r0));

        // Reset while a fill is in flight
        @(negedge clock);
        address = 10'h040;
        wait_mem_read(6'h04);
        mem_hold = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_mem_read", 32'(mem_read), 32'd0);
        check("mid_rst_busy", 32'(busywait), 32'd0);
        check("mid_rst_addr", 32'(mem_address), 32'd0);
        check("mid_rst_instr", instruction, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        address = 10'h000;
        #1;
        check("post_rst_miss", 32'(busywait), 32'd1);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (mem_read) bad = 1'b1;
        end
        check("post_rst_no_read", 32'(bad), 32'd0);
        mem_hold = 1'b0;
        wait_ready(st);
        check("post_rst_blk", 32'(last_blk), 32'h00);
        check("post_rst_instr", instruction, exp_word(10'h000));

        // Address change during a fill
        @(negedge clock);
        address = 10'h020;
        wait_mem_read(6'h02);
        @(negedge clock);
        address = 10'h030;
        #1;
        check("midfill_addr_stable", 32'(mem_address), 32'h02);
        wait_mem_read(6'h03);
        wait_ready(st);
        check("midfill_instr3", instruction, exp_word(10'h030));
        r0 = reads;
        fetch(10'h028, st);
        check("midfill_line2_stall", 32'(st), 32'd0);
        check("midfill_line2_instr", instruction, exp_word(10'h028));
        check("midfill_reads", 32'(reads), 32'(r0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
